// File: rtl/exec_sequencer.sv
// Multi-cycle sequencer for the 8-bit accumulator datapath: fetch/exec/iterative divide/halt.
// Optional macro SEQ_SEG_DISP_EN builds a registered 7-segment decode of pc on pc_disp.
module exec_sequencer (
   input  logic       clk,
   input  logic       pc_reset,
   input  logic       run,
   input  logic       step,
   output logic [3:0] inst_addr,
   input  logic [7:0] inst_data,
   output logic [3:0] rf_addr,
   input  logic [7:0] rf_rdata,
   output logic       rf_we,
   output logic [7:0] rf_wdata,
   output logic [3:0] pc,
   output logic [7:0] ACC,
   output logic [7:0] EXT,
   output logic       c_b,
   output logic       busy,
   output logic       halted,
   output logic       dz,
   output logic [6:0] pc_disp
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_DIV   = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_ir;
   logic [7:0] r_acc;
   logic [7:0] r_ext;
   logic [7:0] r_dvd;
   logic [7:0] r_dvs;
   logic [7:0] r_rem;
   logic [3:0] r_pc;
   logic [3:0] w_pc_nxt;
   logic [2:0] r_cnt;
   logic       r_cb;
   logic       r_dz;
   logic [3:0] w_op;
   logic [3:0] w_sub;
   logic [8:0] w_trial;
   logic [8:0] w_diff;
   logic       w_qbit;
   logic [7:0] w_rem_nxt;

   assign w_op  = r_ir[7:4];
   assign w_sub = r_ir[3:0];

   // One restoring-division step: bring in the next dividend bit, subtract if it fits.
   assign w_trial   = {r_rem, r_dvd[7]};
   assign w_diff    = w_trial - {1'b0, r_dvs};
   assign w_qbit    = (w_trial >= {1'b0, r_dvs});
   assign w_rem_nxt = w_qbit ? w_diff[7:0] : w_trial[7:0];

   // State register
   always_ff @(posedge clk or negedge pc_reset) begin
      if (!pc_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and next pc
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      case (r_state)
         S_IDLE: begin
            if (run || step) begin
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FETCH: w_state_nxt = S_EXEC;
         S_EXEC: begin
            if (r_ir == 8'h0F) begin
               w_state_nxt = S_HALT;
            end else if (w_op == 4'h4) begin
               w_state_nxt = S_DIV;
            end else if (run) begin
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_IDLE;
            end
            // Halt parks pc on its own address; jumps and taken branches load IR[3:0].
            if (r_ir == 8'h0F) begin
               w_pc_nxt = r_pc;
            end else if ((w_op == 4'h8) || ((w_op == 4'hB) && r_cb)) begin
               w_pc_nxt = w_sub;
            end else begin
               w_pc_nxt = r_pc + 4'd1;
            end
         end
         S_DIV: begin
            if (r_cnt != 3'd7) begin
               w_state_nxt = S_DIV;
            end else if (run) begin
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: IR, pc, ACC, EXT, flags and divider state
   always_ff @(posedge clk or negedge pc_reset) begin
      if (!pc_reset) begin
         r_ir  <= 8'h00;
         r_pc  <= 4'h0;
         r_acc <= 8'h00;
         r_ext <= 8'h00;
         r_cb  <= 1'b0;
         r_dz  <= 1'b0;
         r_dvd <= 8'h00;
         r_dvs <= 8'h00;
         r_rem <= 8'h00;
         r_cnt <= 3'd0;
      end else begin
         case (r_state)
            S_FETCH: r_ir <= inst_data;
            S_EXEC: begin
               r_pc <= w_pc_nxt;
               case (w_op)
                  4'h0: begin
                     case (w_sub)
                        4'h1:    r_acc <= {r_acc[6:0], 1'b0};
                        4'h2:    r_acc <= {1'b0, r_acc[7:1]};
                        4'h3:    r_acc <= {r_acc[0], r_acc[7:1]};
                        4'h4:    r_acc <= {r_acc[6:0], r_acc[7]};
                        4'h5:    r_acc <= {r_acc[7], r_acc[7:1]};
                        4'h6:    {r_cb, r_acc} <= {1'b0, r_acc} + 9'd1;
                        4'h7:    {r_cb, r_acc} <= {1'b0, r_acc} - 9'd1;
                        default: r_acc <= r_acc;
                     endcase
                  end
                  4'h1: {r_cb, r_acc} <= {1'b0, r_acc} + {1'b0, rf_rdata};
                  4'h2: {r_cb, r_acc} <= {1'b0, r_acc} - {1'b0, rf_rdata};
                  4'h3: {r_ext, r_acc} <= {8'h00, r_acc} * {8'h00, rf_rdata};
                  4'h4: begin
                     r_dvd <= r_acc;
                     r_dvs <= rf_rdata;
                     r_rem <= 8'h00;
                     r_acc <= 8'h00;
                     r_cnt <= 3'd0;
                  end
                  4'h5:    r_acc <= r_acc & rf_rdata;
                  4'h6:    r_acc <= r_acc ^ rf_rdata;
                  4'h7:    r_cb  <= (r_acc < rf_rdata);
                  4'h9:    r_acc <= rf_rdata;
                  default: r_acc <= r_acc;
               endcase
            end
            S_DIV: begin
               r_cnt <= r_cnt + 3'd1;
               // A zero divisor leaves r_dvd unshifted so the dividend is still there at the end.
               if (r_dvs == 8'h00) begin
                  if (r_cnt == 3'd7) begin
                     r_acc <= 8'hFF;
                     r_ext <= r_dvd;
                     r_dz  <= 1'b1;
                  end else begin
                     r_acc <= r_acc;
                  end
               end else begin
                  r_rem <= w_rem_nxt;
                  r_dvd <= {r_dvd[6:0], 1'b0};
                  r_acc <= {r_acc[6:0], w_qbit};
                  if (r_cnt == 3'd7) begin
                     r_ext <= w_rem_nxt;
                  end else begin
                     r_ext <= r_ext;
                  end
               end
            end
            default: r_ir <= r_ir;
         endcase
      end
   end

`ifdef SEQ_SEG_DISP_EN
   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0:    seg7 = 7'b1000000;
         4'h1:    seg7 = 7'b1111001;
         4'h2:    seg7 = 7'b0100100;
         4'h3:    seg7 = 7'b0110000;
         4'h4:    seg7 = 7'b0011001;
         4'h5:    seg7 = 7'b0010010;
         4'h6:    seg7 = 7'b0000010;
         4'h7:    seg7 = 7'b1111000;
         4'h8:    seg7 = 7'b0000000;
         4'h9:    seg7 = 7'b0010000;
         4'hA:    seg7 = 7'b0001000;
         4'hB:    seg7 = 7'b0000011;
         4'hC:    seg7 = 7'b1000110;
         4'hD:    seg7 = 7'b0100001;
         4'hE:    seg7 = 7'b0000110;
         4'hF:    seg7 = 7'b0001110;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   logic [6:0] r_pc_disp;

   // Display register tracks the pc value being loaded on the same edge
   always_ff @(posedge clk or negedge pc_reset) begin
      if (!pc_reset) begin
         r_pc_disp <= 7'b1000000;
      end else begin
         r_pc_disp <= seg7(w_pc_nxt);
      end
   end

   assign pc_disp = r_pc_disp;
`else
   assign pc_disp = 7'b1111111;
`endif

   assign inst_addr = r_pc;
   assign pc        = r_pc;
   assign rf_addr   = r_ir[3:0];
   assign rf_wdata  = r_acc;
   assign rf_we     = (r_state == S_EXEC) && (w_op == 4'hA);
   assign ACC       = r_acc;
   assign EXT       = r_ext;
   assign c_b       = r_cb;
   assign dz        = r_dz;
   assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
   assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed programs plus random programs stepped one
// instruction at a time against an instruction-level model of the ISA.
module tb_exec_sequencer;

   logic       clk = 1'b0;
   logic       pc_reset;
   logic       run;
   logic       step;
   logic [3:0] inst_addr;
   logic [7:0] inst_data;
   logic [3:0] rf_addr;
   logic [7:0] rf_rdata;
   logic       rf_we;
   logic [7:0] rf_wdata;
   logic [3:0] pc;
   logic [7:0] ACC;
   logic [7:0] EXT;
   logic       c_b;
   logic       busy;
   logic       halted;
   logic       dz;
   logic [6:0] pc_disp;

   logic [7:0] imem [16];
   logic [7:0] rf [16];
   logic [7:0] rf_init [16];
   logic       rf_load = 1'b0;

   logic [7:0] m_acc, m_ext;
   logic [3:0] m_pc;
   logic       m_cb, m_dz, m_halt;
   logic [7:0] m_rf [16];
   int         m_cyc;

   int n_checks = 0;
   int n_pass   = 0;

   exec_sequencer dut (
      .clk(clk), .pc_reset(pc_reset), .run(run), .step(step),
      .inst_addr(inst_addr), .inst_data(inst_data),
      .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wdata(rf_wdata),
      .pc(pc), .ACC(ACC), .EXT(EXT), .c_b(c_b), .busy(busy), .halted(halted),
      .dz(dz), .pc_disp(pc_disp)
   );

   always #5 clk = ~clk;

   assign inst_data = imem[inst_addr];
   assign rf_rdata  = rf[rf_addr];

   // Register-file memory: bulk preload from the bench, otherwise DUT writes
   always @(posedge clk) begin
      if (rf_load) begin
         for (int i = 0; i < 16; i++) rf[i] <= rf_init[i];
      end else if (rf_we) begin
         rf[rf_addr] <= rf_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] seg_ref(input logic [3:0] v);
`ifdef SEQ_SEG_DISP_EN
      logic [6:0] tbl [16];
      tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return tbl[v];
`else
      return 7'b1111111 | {3'b000, v & 4'h0};
`endif
   endfunction

   // Instruction-level model: applies one instruction's architectural effect.
   task automatic model_exec();
      logic [7:0] ir, r, a;
      logic [3:0] n, npc;
      int         s, prod;
      ir    = imem[m_pc];
      n     = ir[3:0];
      r     = m_rf[n];
      a     = m_acc;
      npc   = m_pc + 4'd1;
      m_cyc = 2;
      case (ir[7:4])
         4'h0: begin
            case (n)
               4'h1: m_acc = 8'((int'(a) * 2) % 256);
               4'h2: m_acc = a / 8'd2;
               4'h3: m_acc = 8'((a / 2) + (a % 2) * 128);
               4'h4: m_acc = 8'(((int'(a) * 2) % 256) + a / 128);
               4'h5: m_acc = 8'((a / 2) + (a / 128) * 128);
               4'h6: begin s = int'(a) + 1; m_cb = (s > 255); m_acc = 8'(s % 256); end
               4'h7: begin m_cb = (a == 8'd0); m_acc = 8'((int'(a) + 255) % 256); end
               4'hF: begin m_halt = 1'b1; npc = m_pc; end
               default: ;
            endcase
         end
         4'h1: begin s = int'(a) + int'(r); m_cb = (s > 255); m_acc = 8'(s % 256); end
         4'h2: begin m_cb = (a < r); m_acc = 8'((int'(a) - int'(r) + 256) % 256); end
         4'h3: begin prod = int'(a) * int'(r); m_ext = 8'(prod / 256); m_acc = 8'(prod % 256); end
         4'h4: begin
            m_cyc = 10;
            if (r == 8'd0) begin
               m_acc = 8'hFF; m_ext = a; m_dz = 1'b1;
            end else begin
               m_acc = a / r; m_ext = a % r;
            end
         end
         4'h5: m_acc = a & r;
         4'h6: m_acc = a ^ r;
         4'h7: m_cb = (a < r);
         4'h8: npc = n;
         4'h9: m_acc = r;
         4'hA: m_rf[n] = a;
         4'hB: if (m_cb) npc = n;
         default: ;
      endcase
      m_pc = npc;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      run = 1'b0; step = 1'b0;
      for (int i = 0; i < 16; i++) rf_init[i] = m_rf[i];
      rf_load = 1'b1;
      pc_reset = 1'b0;
      @(negedge clk);
      rf_load = 1'b0;
      pc_reset = 1'b1;
      m_acc = 8'h00; m_ext = 8'h00; m_pc = 4'h0;
      m_cb = 1'b0; m_dz = 1'b0; m_halt = 1'b0;
   endtask

   task automatic do_step(input bit extra, output int cyc);
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         step = extra && (cyc == 2);
         @(negedge clk);
      end
      step = 1'b0;
      @(negedge clk);
      check("idle_after_step", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_acc"}, 32'(ACC), 32'(m_acc));
      check({tag, "_ext"}, 32'(EXT), 32'(m_ext));
      check({tag, "_cb"}, {31'd0, c_b}, {31'd0, m_cb});
      check({tag, "_dz"}, {31'd0, dz}, {31'd0, m_dz});
      check({tag, "_pc"}, 32'(pc), 32'(m_pc));
      check({tag, "_halted"}, {31'd0, halted}, {31'd0, m_halt});
      check({tag, "_disp"}, 32'(pc_disp), 32'(seg_ref(m_pc)));
   endtask

   task automatic run_steps(input string tag, input int nsteps);
      int cyc;
      for (int i = 0; i < nsteps; i++) begin
         if (m_halt) break;
         do_step(($urandom % 3) == 0, cyc);
         model_exec();
         check({tag, "_cycles"}, 32'(cyc), 32'(m_cyc));
         check_state(tag);
      end
      for (int i = 0; i < 16; i++) check({tag, "_rf"}, 32'(rf[i]), 32'(m_rf[i]));
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) begin imem[i] = 8'h00; m_rf[i] = 8'h00; end
   endtask

   initial begin
      int cyc;
      pc_reset = 1'b0; run = 1'b0; step = 1'b0;
      clear_mem();
      reset_dut();

      // Reset values
      check("rst_acc", 32'(ACC), 32'h0);
      check("rst_ext", 32'(EXT), 32'h0);
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_flags", {28'd0, c_b, dz, busy, halted}, 32'h0);
      check("rst_we", {31'd0, rf_we}, 32'd0);
      check("rst_disp", 32'(pc_disp), 32'(seg_ref(4'h0)));

      // Free-run program ending in halt
      clear_mem();
      m_rf[5] = 8'd5; m_rf[3] = 8'd2;
      imem[0] = 8'h95; imem[1] = 8'h23; imem[2] = 8'hA9; imem[3] = 8'h0F;
      reset_dut();
      run = 1'b1;
      cyc = 0;
      while (!halted && cyc < 200) begin cyc++; @(negedge clk); end
      run = 1'b0;
      check("run_halt_reached", {31'd0, halted}, 32'd1);
      check("run_acc", 32'(ACC), 32'h03);
      check("run_r9", 32'(rf[9]), 32'h03);
      check("run_cb", {31'd0, c_b}, 32'd0);
      check("run_pc", 32'(pc), 32'd3);
      check("run_busy", {31'd0, busy}, 32'd0);

      // Divide 0x13/3, divide by zero with sticky dz, compare/branch both ways
      clear_mem();
      m_rf[1] = 8'h13; m_rf[3] = 8'd3; m_rf[10] = 8'h2A; m_rf[5] = 8'd5;
      m_rf[7] = 8'd20; m_rf[8] = 8'd25;
      imem[0] = 8'h91; imem[1] = 8'h43; imem[2] = 8'h9A; imem[3] = 8'h40;
      imem[4] = 8'h06; imem[5] = 8'h95; imem[6] = 8'h77; imem[7] = 8'hB9;
      imem[9] = 8'h98; imem[10] = 8'h77; imem[11] = 8'hB0; imem[12] = 8'h0F;
      reset_dut();
      run_steps("dir", 16);
      check("dir_dz_sticky", {31'd0, dz}, 32'd1);

      // Reset in the 4th DIV cycle aborts with no partial result
      clear_mem();
      m_rf[1] = 8'h50; m_rf[2] = 8'h10; m_rf[3] = 8'd3;
      imem[0] = 8'h91; imem[1] = 8'h32; imem[2] = 8'h91; imem[3] = 8'h43;
      reset_dut();
      run_steps("pre_abort", 3);
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      pc_reset = 1'b0;
      #1;
      check("abort_acc", 32'(ACC), 32'h0);
      check("abort_ext", 32'(EXT), 32'h0);
      check("abort_pc", 32'(pc), 32'h0);
      check("abort_state", {29'd0, busy, halted, rf_we}, 32'h0);
      @(negedge clk);
      pc_reset = 1'b1;

      // Random programs stepped one instruction at a time
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 16; i++) begin
            imem[i] = 8'($urandom);
            m_rf[i] = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
            if ((i == 0) && (imem[i] == 8'h0F)) imem[i] = 8'h1F;
         end
         reset_dut();
         run_steps("rnd", 24);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control sequencer for the 8-bit accumulator datapath. It fetches from the 16-entry instruction memory and drives the 16×8 register-file port. It owns ACC, EXT and the carry/borrow flag, and executes the 4-bit-opcode instruction set. Divide runs iteratively over 8 cycles instead of as a single combinational loop. The sequencer sits between the board-level run/step controls and the register file / instruction ROM, and supports free-run, single-step and halt.

## Interface
- No parameters; widths are fixed (8-bit data, 4-bit PC and register index).
- `clk`  in  1  system clock; all state on the rising edge.
- `pc_reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = free-run instructions.
- `step`  in  1  one-cycle pulse; executes exactly one instruction when idle and `run`=0.
- `inst_addr`  out  4  instruction-memory address, always equals `pc`.
- `inst_data`  in  8  instruction byte, combinational from `inst_addr`.
- `rf_addr`  out  4  register-file index, equals IR[3:0].
- `rf_rdata`  in  8  register-file read data, combinational from `rf_addr`.
- `rf_we`  out  1  register-file write strobe, one cycle.
- `rf_wdata`  out  8  write data, equals ACC.
- `pc`  out  4  program counter.
- `ACC`  out  8  accumulator.
- `EXT`  out  8  extension register: multiply high byte, divide remainder.
- `c_b`  out  1  carry/borrow/compare flag.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.
- `dz`  out  1  sticky divide-by-zero flag.
- `pc_disp`  out  7  active-low 7-segment pattern of `pc`; see Configuration.

## Operation
- States:
  - IDLE: if `run`=1 or `step`=1, go to FETCH.
  - FETCH: IR <= `inst_data`; go to EXEC.
  - EXEC: perform the op on the operand R = `rf_rdata`.
    - Divide goes to DIV.
    - IR=0x0F goes to HALT.
    - All other ops complete here; then go to FETCH if `run`=1, else IDLE.
  - DIV: 8 iterations; then go to FETCH or IDLE by the same `run` rule.
  - HALT: terminal; left only by reset.
- PC: after a non-jump op, pc <= pc+1 (wraps 15→0). Jumps load the target instead.
- `step` is ignored while `busy` or `run`=1.
- Dropping `run` mid-instruction finishes that instruction, then the sequencer enters IDLE.
- Op 0x (IR[3:0] selects the operation):
  - 0 nop; 1 shl; 2 shr.
  - 3 ror: ACC[7] <= old ACC[0].
  - 4 rol: ACC[0] <= old ACC[7].
  - 5 asr: sign bit kept.
  - 6 inc, {c_b,ACC} <= ACC+1.
  - 7 dec, {c_b,ACC} <= ACC−1 (9-bit; c_b=1 on borrow).
  - F halt.
  - 8–E nop.
- Register ops, operand R:
  - 1x add, {c_b,ACC} <= ACC+R.
  - 2x sub, {c_b,ACC} <= ACC−R (9-bit).
  - 3x mul, {EXT,ACC} <= ACC×R (16-bit).
  - 4x div.
  - 5x and.
  - 6x xor.
  - 7x cmp, c_b <= (ACC<R) unsigned; ACC unchanged.
  - 8x jmp, pc <= IR[3:0].
  - 9x ld, ACC <= R.
  - Ax st, `rf_we`=1 for the EXEC cycle with `rf_wdata`=ACC.
  - Bx branch, pc <= IR[3:0] if c_b=1, else pc+1.
  - C–F nop.
- Divide: restoring shift-subtract on an unsigned dividend.
  - EXEC latches dividend=ACC and divisor=R, and clears the quotient and remainder.
  - Each DIV cycle shifts one dividend bit into the remainder (MSB first). It subtracts the divisor if remainder ≥ divisor and shifts the quotient bit into ACC.
  - After 8 cycles: ACC = quotient, EXT = remainder.
  - Divisor 0: skip the iterations result; ACC <= 0xFF, EXT <= dividend, `dz` <= 1. Still spends 8 DIV cycles. `dz` clears only on reset.
- Flags: c_b is touched only by add, sub, inc, dec and cmp. EXT is touched only by mul and div.

## Timing
- Reset values: state IDLE, pc 0, ACC 0x00, EXT 0x00, c_b 0, dz 0, busy 0, halted 0, rf_we 0, IR 0x00.
  - `pc_disp`: 7'b1000000 with the macro defined, 7'b1111111 without.
- Reset is asynchronous in every state. Mid-DIV it aborts with no partial result, and `rf_we` drops immediately.
- Latency from entering FETCH:
  - Non-divide instructions: 2 cycles.
  - Divide: 10 cycles.
- The IDLE→FETCH decision adds 1 cycle.
- `rf_we` is high for exactly one cycle (the st EXEC cycle); writes take effect at that edge.
- `halted` rises on the edge leaving EXEC of 0x0F. pc then stays at the halt address.

## Configuration
- `SEQ_SEG_DISP_EN` defined: `pc_disp` is a registered hex decode of `pc`, updated on every pc change. Segment patterns 0–F (active-low, g..a):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, B 0000011
  - C 1000110, D 0100001, E 0000110, F 0001110
- Not defined: `pc_disp` is constant 7'b1111111; no decode logic is built.

## Test plan
- R5=5, R3=2; program 95,23,A9,0F; `run`=1 → ACC=0x03, R9=0x03, c_b=0, halted=1, pc=3.
- ACC=0x13 via ld, R3=3; op 43 → busy for 10 cycles from FETCH; then ACC=0x06, EXT=0x01, dz=0.
- ACC=0x2A, R0=0; op 40 → ACC=0xFF, EXT=0x2A, dz=1. dz stays 1 through later instructions until `pc_reset` pulses low.
- `run`=0; pulse `step` 3 times → exactly 3 instructions retire, pc=3. A `step` pulsed while busy is ignored.
- ACC=5, R7=20; ops 77 then B9 → c_b=1 and pc=9. With ACC=25 instead → c_b=0 and pc advances by 1.
- Assert `pc_reset` low in the 4th DIV cycle → ACC, EXT and pc read 0 immediately, state IDLE, no rf_we pulse.
